// File: rtl/sobel_cfg_ctrl.sv
// Sobel pipeline configuration controller: shadows FIR coefficients and commits them on
// the next frame start, and serves AXI-side histogram bin reads from the histogram RAM.
module sobel_cfg_ctrl #(
    parameter int unsigned NCOEF   = 9,
    parameter int unsigned COEF_W  = 16,
    parameter int unsigned HIST_AW = 8,
    parameter int unsigned HIST_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               axi_wr_strobe_i,
    input  logic [3:0]         fir_addr_i,
    input  logic [COEF_W-1:0]  fir_coeff_i,
    output logic               axi_wr_ack_o,
    input  logic               axi_rd_strobe_i,
    output logic               axi_rd_ack_o,
    output logic [HIST_W-1:0]  hist_bin_o,
    input  logic               vs_i,
    output logic               coef_we_o,
    output logic [3:0]         coef_addr_o,
    output logic [COEF_W-1:0]  coef_data_o,
    output logic               hist_rd_en_o,
    output logic [HIST_AW-1:0] hist_rd_addr_o,
    input  logic [HIST_W-1:0]  hist_rd_data_i,
    output logic               hist_clr_o,
    output logic               busy_o
);

    typedef enum logic {IDLE, COMMIT} cstate_e;
    typedef enum logic [1:0] {R_IDLE, R_REQ, R_CAP, R_ACK} rstate_e;

    logic [COEF_W-1:0] r_shadow [NCOEF];
    logic              r_dirty;
    logic              r_vs;
    logic              r_wr_ack;
    logic              w_vs_rise;
    logic              w_wr_hit;
    logic              w_commit_start;

    cstate_e           r_cstate, w_cstate_d;
    logic              r_coef_we, w_coef_we_d;
    logic [3:0]        r_coef_addr, w_coef_addr_d;
    logic [COEF_W-1:0] r_coef_data, w_coef_data_d;
    logic              r_busy, w_busy_d;

    rstate_e            r_rstate, w_rstate_d;
    logic               r_rd_en, w_rd_en_d;
    logic [HIST_AW-1:0] r_rd_addr, w_rd_addr_d;
    logic [HIST_AW-1:0] r_bin_idx, w_bin_idx_d;
    logic [HIST_W-1:0]  r_hist_bin, w_hist_bin_d;
    logic               r_rd_ack, w_rd_ack_d;
    logic               r_clr, w_clr_d;

    assign w_vs_rise      = vs_i & ~r_vs;
    assign w_wr_hit       = axi_wr_strobe_i && (32'(fir_addr_i) < NCOEF);
    assign w_commit_start = (r_cstate == IDLE) && w_vs_rise && r_dirty;

    // Out-of-range writes are still acknowledged but touch neither shadow nor dirty.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCOEF; i++) r_shadow[i] <= '0;
            r_dirty  <= 1'b0;
            r_vs     <= 1'b0;
            r_wr_ack <= 1'b0;
        end else begin
            r_vs     <= vs_i;
            r_wr_ack <= axi_wr_strobe_i;
            if (w_wr_hit) r_shadow[fir_addr_i] <= fir_coeff_i;
            // A write landing on the commit entry cycle must still force a recommit.
            if (w_wr_hit)            r_dirty <= 1'b1;
            else if (w_commit_start) r_dirty <= 1'b0;
        end
    end

    always_comb begin
        w_cstate_d    = r_cstate;
        w_coef_we_d   = 1'b0;
        w_coef_addr_d = r_coef_addr;
        w_coef_data_d = r_coef_data;
        w_busy_d      = 1'b0;
        unique case (r_cstate)
            IDLE: begin
                if (w_commit_start) begin
                    w_cstate_d    = COMMIT;
                    w_coef_we_d   = 1'b1;
                    w_coef_addr_d = 4'd0;
                    w_coef_data_d = r_shadow[0];
                    w_busy_d      = 1'b1;
                end
            end
            COMMIT: begin
                if (r_coef_addr == 4'(NCOEF - 1)) begin
                    w_cstate_d = IDLE;
                end else begin
                    w_coef_we_d   = 1'b1;
                    w_coef_addr_d = r_coef_addr + 4'd1;
                    w_coef_data_d = r_shadow[r_coef_addr + 4'd1];
                    w_busy_d      = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cstate    <= IDLE;
            r_coef_we   <= 1'b0;
            r_coef_addr <= '0;
            r_coef_data <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_cstate    <= w_cstate_d;
            r_coef_we   <= w_coef_we_d;
            r_coef_addr <= w_coef_addr_d;
            r_coef_data <= w_coef_data_d;
            r_busy      <= w_busy_d;
        end
    end

    // Bin index advances as the ack is issued; the last bin also clears the histogram.
    always_comb begin
        w_rstate_d   = r_rstate;
        w_rd_en_d    = 1'b0;
        w_rd_addr_d  = r_rd_addr;
        w_bin_idx_d  = r_bin_idx;
        w_hist_bin_d = r_hist_bin;
        w_rd_ack_d   = 1'b0;
        w_clr_d      = 1'b0;
        unique case (r_rstate)
            R_IDLE: begin
                if (axi_rd_strobe_i) begin
                    w_rstate_d  = R_REQ;
                    w_rd_en_d   = 1'b1;
                    w_rd_addr_d = r_bin_idx;
                end
            end
            R_REQ: w_rstate_d = R_CAP;
            R_CAP: begin
                w_rstate_d   = R_ACK;
                w_hist_bin_d = hist_rd_data_i;
                w_rd_ack_d   = 1'b1;
                w_clr_d      = (r_bin_idx == {HIST_AW{1'b1}});
                w_bin_idx_d  = r_bin_idx + 1'b1;
            end
            R_ACK: w_rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate   <= R_IDLE;
            r_rd_en    <= 1'b0;
            r_rd_addr  <= '0;
            r_bin_idx  <= '0;
            r_hist_bin <= '0;
            r_rd_ack   <= 1'b0;
            r_clr      <= 1'b0;
        end else begin
            r_rstate   <= w_rstate_d;
            r_rd_en    <= w_rd_en_d;
            r_rd_addr  <= w_rd_addr_d;
            r_bin_idx  <= w_bin_idx_d;
            r_hist_bin <= w_hist_bin_d;
            r_rd_ack   <= w_rd_ack_d;
            r_clr      <= w_clr_d;
        end
    end

    assign axi_wr_ack_o   = r_wr_ack;
    assign coef_we_o      = r_coef_we;
    assign coef_addr_o    = r_coef_addr;
    assign coef_data_o    = r_coef_data;
    assign busy_o         = r_busy;
    assign hist_rd_en_o   = r_rd_en;
    assign hist_rd_addr_o = r_rd_addr;
    assign hist_bin_o     = r_hist_bin;
    assign axi_rd_ack_o   = r_rd_ack;
    assign hist_clr_o     = r_clr;

endmodule

// File: tb/tb_sobel_cfg_ctrl.sv
// Self-checking bench for sobel_cfg_ctrl: a coefficient/histogram reference model
// tracks expected commits and bin reads under directed and randomized stimulus.
module tb_sobel_cfg_ctrl;

    localparam int NCOEF   = 9;
    localparam int COEF_W  = 16;
    localparam int HIST_AW = 8;
    localparam int HIST_W  = 16;
    localparam int NBIN    = 256;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               axi_wr_strobe_i = 1'b0;
    logic [3:0]         fir_addr_i = '0;
    logic [COEF_W-1:0]  fir_coeff_i = '0;
    logic               axi_wr_ack_o;
    logic               axi_rd_strobe_i = 1'b0;
    logic               axi_rd_ack_o;
    logic [HIST_W-1:0]  hist_bin_o;
    logic               vs_i = 1'b0;
    logic               coef_we_o;
    logic [3:0]         coef_addr_o;
    logic [COEF_W-1:0]  coef_data_o;
    logic               hist_rd_en_o;
    logic [HIST_AW-1:0] hist_rd_addr_o;
    logic [HIST_W-1:0]  hist_rd_data_i = '0;
    logic               hist_clr_o;
    logic               busy_o;

    sobel_cfg_ctrl #(
        .NCOEF(NCOEF), .COEF_W(COEF_W), .HIST_AW(HIST_AW), .HIST_W(HIST_W)
    ) dut (
        .clk(clk), .rst(rst),
        .axi_wr_strobe_i(axi_wr_strobe_i), .fir_addr_i(fir_addr_i),
        .fir_coeff_i(fir_coeff_i), .axi_wr_ack_o(axi_wr_ack_o),
        .axi_rd_strobe_i(axi_rd_strobe_i), .axi_rd_ack_o(axi_rd_ack_o),
        .hist_bin_o(hist_bin_o), .vs_i(vs_i),
        .coef_we_o(coef_we_o), .coef_addr_o(coef_addr_o), .coef_data_o(coef_data_o),
        .hist_rd_en_o(hist_rd_en_o), .hist_rd_addr_o(hist_rd_addr_o),
        .hist_rd_data_i(hist_rd_data_i), .hist_clr_o(hist_clr_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // Histogram RAM model: one-cycle read latency.
    logic [HIST_W-1:0] ram_mem [NBIN];
    always @(posedge clk) if (hist_rd_en_o) hist_rd_data_i <= ram_mem[hist_rd_addr_o];

    // Reference model state.
    logic [COEF_W-1:0] shadow_m [NCOEF];
    bit                dirty_m;
    int                bin_m;
    int                clr_cnt;
    int                checks = 0;
    int                errors = 0;

    task automatic model_reset();
        for (int k = 0; k < NCOEF; k++) shadow_m[k] = '0;
        dirty_m = 0;
        bin_m   = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        axi_wr_strobe_i = 1'b0;
        axi_rd_strobe_i = 1'b0;
        vs_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({axi_wr_ack_o, axi_rd_ack_o, coef_we_o, hist_rd_en_o, hist_clr_o, busy_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {axi_wr_ack_o, axi_rd_ack_o, coef_we_o, hist_rd_en_o, hist_clr_o, busy_o});
        end
        checks++;
        if (coef_addr_o !== 4'd0 || coef_data_o !== 16'd0 || hist_rd_addr_o !== 8'd0 ||
            hist_bin_o !== 16'd0) begin
            errors++;
            $display("FAIL reset_data: got %h/%h/%h/%h expected all 0",
                     coef_addr_o, coef_data_o, hist_rd_addr_o, hist_bin_o);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic do_write(input int addr, input logic [COEF_W-1:0] data);
        @(negedge clk);
        axi_wr_strobe_i = 1'b1;
        fir_addr_i      = 4'(addr);
        fir_coeff_i     = data;
        if (addr < NCOEF) begin
            shadow_m[addr] = data;
            dirty_m = 1;
        end
        @(negedge clk);
        axi_wr_strobe_i = 1'b0;
        checks++;
        if (axi_wr_ack_o !== 1'b1) begin
            errors++;
            $display("FAIL wr_ack addr %0d: got %b expected 1", addr, axi_wr_ack_o);
        end
        @(negedge clk);
        checks++;
        if (axi_wr_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL wr_ack_pulse addr %0d: got %b expected 0", addr, axi_wr_ack_o);
        end
    endtask

    // Raise vs for one frame start; optionally write coefficient 0 at cycle wr_off.
    task automatic vs_frame(input int wr_off, input logic [COEF_W-1:0] wr_data);
        logic [COEF_W-1:0] exp_v [NCOEF];
        bit   exp_commit;
        int   cnt;
        logic exp_busy;
        exp_commit = dirty_m;
        for (int k = 0; k < NCOEF; k++) exp_v[k] = shadow_m[k];
        if (exp_commit) dirty_m = 0;
        cnt = 0;
        @(negedge clk);
        vs_i = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 5) vs_i = 1'b0;
            if (coef_we_o === 1'b1) begin
                checks++;
                if (!exp_commit || cnt >= NCOEF || i != cnt + 1 || coef_addr_o !== 4'(cnt) ||
                    coef_data_o !== exp_v[cnt % NCOEF]) begin
                    errors++;
                    $display("FAIL commit_beat %0d: got addr %0d data %h expected addr %0d data %h",
                             i, coef_addr_o, coef_data_o, cnt, exp_v[cnt % NCOEF]);
                end
                cnt++;
            end
            exp_busy = exp_commit && (i <= NCOEF);
            checks++;
            if (busy_o !== exp_busy) begin
                errors++;
                $display("FAIL busy cycle %0d: got %b expected %b", i, busy_o, exp_busy);
            end
            if (wr_off > 0 && i == wr_off + 1) begin
                axi_wr_strobe_i = 1'b0;
                checks++;
                if (axi_wr_ack_o !== 1'b1) begin
                    errors++;
                    $display("FAIL commit_wr_ack: got %b expected 1", axi_wr_ack_o);
                end
            end
            if (wr_off > 0 && i == wr_off) begin
                axi_wr_strobe_i = 1'b1;
                fir_addr_i      = 4'd0;
                fir_coeff_i     = wr_data;
                shadow_m[0]     = wr_data;
                dirty_m         = 1;
            end
        end
        checks++;
        if (cnt != (exp_commit ? NCOEF : 0)) begin
            errors++;
            $display("FAIL commit_count: got %0d expected %0d", cnt, exp_commit ? NCOEF : 0);
        end
    endtask

    task automatic do_read();
        logic [HIST_W-1:0] exp_bin;
        exp_bin = ram_mem[bin_m];
        @(negedge clk);
        axi_rd_strobe_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            axi_rd_strobe_i = 1'b0;
            if (i == 1) begin
                checks++;
                if (hist_rd_en_o !== 1'b1 || hist_rd_addr_o !== 8'(bin_m)) begin
                    errors++;
                    $display("FAIL rd_req: got en %b addr %0d expected en 1 addr %0d",
                             hist_rd_en_o, hist_rd_addr_o, bin_m);
                end
            end
            checks++;
            if (axi_rd_ack_o !== (i == 3)) begin
                errors++;
                $display("FAIL rd_ack cycle %0d: got %b expected %b", i, axi_rd_ack_o, i == 3);
            end
            if (i >= 3) begin
                checks++;
                if (hist_bin_o !== exp_bin) begin
                    errors++;
                    $display("FAIL rd_data bin %0d cycle %0d: got %h expected %h",
                             bin_m, i, hist_bin_o, exp_bin);
                end
            end
            checks++;
            if (hist_clr_o !== (i == 3 && bin_m == NBIN - 1)) begin
                errors++;
                $display("FAIL hist_clr bin %0d cycle %0d: got %b", bin_m, i, hist_clr_o);
            end
            if (hist_clr_o === 1'b1) clr_cnt++;
        end
        bin_m = (bin_m + 1) % NBIN;
    endtask

    task automatic test_coef_commit();
        do_write(2, 16'h0123);
        vs_frame(0, '0);
        do_write(12, 16'hFFFF);
        vs_frame(0, '0);
    endtask

    task automatic test_write_during_commit();
        do_write(4, 16'($urandom));
        vs_frame(3, 16'h0005);
        vs_frame(0, '0);
        vs_frame(0, '0);
    endtask

    task automatic test_random_writes();
        for (int r = 0; r < 8; r++) begin
            int nw;
            nw = $urandom_range(0, 4);
            for (int w = 0; w < nw; w++) do_write($urandom_range(0, 15), 16'($urandom));
            vs_frame((r % 3 == 2) ? 3 : 0, 16'($urandom));
        end
        vs_frame(0, '0);
    endtask

    task automatic test_hist_sweep();
        for (int k = 0; k < NBIN; k++) ram_mem[k] = 16'(k);
        clr_cnt = 0;
        for (int n = 0; n < NBIN + 1; n++) do_read();
        checks++;
        if (clr_cnt != 1) begin
            errors++;
            $display("FAIL clr_count: got %0d expected 1", clr_cnt);
        end
    endtask

    task automatic test_read_double();
        logic [HIST_W-1:0] exp_bin;
        exp_bin = ram_mem[bin_m];
        @(negedge clk);
        axi_rd_strobe_i = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i >= 2) axi_rd_strobe_i = 1'b0;
            checks++;
            if (axi_rd_ack_o !== (i == 3)) begin
                errors++;
                $display("FAIL dbl_ack cycle %0d: got %b expected %b", i, axi_rd_ack_o, i == 3);
            end
            if (i == 3) begin
                checks++;
                if (hist_bin_o !== exp_bin) begin
                    errors++;
                    $display("FAIL dbl_data: got %h expected %h", hist_bin_o, exp_bin);
                end
            end
        end
        bin_m = (bin_m + 1) % NBIN;
        do_read();
    endtask

    task automatic test_random_reads();
        for (int k = 0; k < NBIN; k++) ram_mem[k] = 16'($urandom);
        for (int n = 0; n < 20; n++) do_read();
    endtask

    task automatic test_back_to_back_reset();
        logic [HIST_W-1:0] exp_bin;
        int a;
        a = $urandom_range(0, NCOEF - 1);
        exp_bin = ram_mem[bin_m];
        @(negedge clk);
        axi_wr_strobe_i = 1'b1;
        fir_addr_i      = 4'(a);
        fir_coeff_i     = 16'($urandom);
        axi_rd_strobe_i = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            axi_wr_strobe_i = 1'b0;
            axi_rd_strobe_i = (i == 6);
            if (i == 1) begin
                checks++;
                if (axi_wr_ack_o !== 1'b1) begin
                    errors++;
                    $display("FAIL sim_wr_ack: got %b expected 1", axi_wr_ack_o);
                end
            end
            if (i == 3) begin
                checks++;
                if (axi_rd_ack_o !== 1'b1 || hist_bin_o !== exp_bin) begin
                    errors++;
                    $display("FAIL sim_rd_ack: got %b/%h expected 1/%h",
                             axi_rd_ack_o, hist_bin_o, exp_bin);
                end
            end
            if (i == 4) vs_i = 1'b1;
            if (i >= 5 && i <= 8) begin
                checks++;
                if (coef_we_o !== 1'b1 || coef_addr_o !== 4'(i - 5)) begin
                    errors++;
                    $display("FAIL pre_rst_commit cycle %0d: got we %b addr %0d expected 1/%0d",
                             i, coef_we_o, coef_addr_o, i - 5);
                end
            end
            if (i == 8) rst = 1'b1;
            if (i == 9) vs_i = 1'b0;
            if (i == 10) begin
                checks++;
                if ({axi_wr_ack_o, axi_rd_ack_o, coef_we_o, hist_rd_en_o, hist_clr_o, busy_o,
                     coef_addr_o, coef_data_o, hist_rd_addr_o, hist_bin_o} !== '0) begin
                    errors++;
                    $display("FAIL mid_rst_outputs: got we %b addr %0d busy %b ack %b bin %h",
                             coef_we_o, coef_addr_o, busy_o, axi_rd_ack_o, hist_bin_o);
                end
                rst = 1'b0;
                model_reset();
            end
            if (i >= 9) begin
                checks++;
                if (coef_we_o !== 1'b0 || axi_rd_ack_o !== 1'b0 || busy_o !== 1'b0) begin
                    errors++;
                    $display("FAIL post_rst_quiet cycle %0d: got we %b ack %b busy %b expected 0",
                             i, coef_we_o, axi_rd_ack_o, busy_o);
                end
            end
        end
        vs_frame(0, '0);
        vs_frame(0, '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < NBIN; k++) ram_mem[k] = '0;
        clr_cnt = 0;
        model_reset();
        test_reset();
        test_coef_commit();
        test_write_during_commit();
        test_hist_sweep();
        test_random_writes();
        test_read_double();
        test_random_reads();
        test_back_to_back_reset();
        test_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sobel_cfg_ctrl.md
SOBEL_CFG_CTRL -- requirements
Module: sobel_cfg_ctrl

Interface
REQ-001 SHALL have parameter NCOEF, default 9: number of FIR coefficients.
REQ-002 SHALL have parameter COEF_W, default 16: coefficient width.
REQ-003 SHALL have parameter HIST_AW, default 8: histogram bin address width (256 bins).
REQ-004 SHALL have parameter HIST_W, default 16: histogram bin width.
REQ-005 SHALL have one clock and synchronous active-high reset: clk  in  1  pixel clock; all logic on its rising edge.
REQ-006 SHALL have rst  in  1  synchronous reset, active-high.
REQ-007 SHALL have axi_wr_strobe_i  in  1  one-cycle coefficient write request.
REQ-008 SHALL have fir_addr_i  in  4  coefficient index for the write.
REQ-009 SHALL have fir_coeff_i  in  COEF_W  coefficient value for the write.
REQ-010 SHALL have axi_wr_ack_o  out  1  one-cycle write acknowledge.
REQ-011 SHALL have axi_rd_strobe_i  in  1  one-cycle histogram bin read request.
REQ-012 SHALL have axi_rd_ack_o  out  1  one-cycle read acknowledge.
REQ-013 SHALL have hist_bin_o  out  HIST_W  bin value, valid while axi_rd_ack_o=1 and held until the next read.
REQ-014 SHALL have vs_i  in  1  vertical sync from the video stream.
REQ-015 SHALL have coef_we_o / coef_addr_o[3:0] / coef_data_o[COEF_W]  out  FIR coefficient load port.
REQ-016 SHALL have hist_rd_en_o / hist_rd_addr_o[HIST_AW]  out  histogram RAM read port.
REQ-017 SHALL have hist_rd_data_i  in  HIST_W  RAM read data, valid 1 cycle after hist_rd_en_o.
REQ-018 SHALL have hist_clr_o  out  1  one-cycle histogram clear pulse.
REQ-019 SHALL have busy_o  out  1  high while a commit is in progress.

Function
REQ-020 SHALL hold NCOEF shadow registers; a write strobe at cycle N updates shadow[fir_addr_i] and sets the dirty flag; axi_wr_ack_o pulses at N+1.
REQ-021 SHALL acknowledge a write with fir_addr_i>=NCOEF at N+1, without changing the shadow registers or the dirty flag.
REQ-022 SHALL detect the vs_i rising edge as (vs_i=1 and registered vs_i=0).
REQ-023 Commit FSM states are IDLE and COMMIT; IDLE->COMMIT on the vs rising edge when dirty=1, and the entry cycle clears dirty.
REQ-024 In COMMIT, SHALL drive coef_we_o=1 for NCOEF consecutive cycles with coef_addr_o=0..NCOEF-1 and coef_data_o=shadow[addr] as sampled in that cycle, then return to IDLE; busy_o=1 throughout COMMIT.
REQ-025 A write accepted during COMMIT SHALL update the shadow register, be acknowledged at N+1, and set dirty again so that the next frame recommits.
REQ-026 A vs rising edge with dirty=0, or arriving during COMMIT, SHALL be ignored.
REQ-027 Read FSM states are R_IDLE, R_REQ, R_CAP and R_ACK; an axi_rd_strobe_i in R_IDLE at cycle N drives hist_rd_en_o=1 with hist_rd_addr_o=bin_idx at N+1.
REQ-028 The read FSM SHALL capture hist_rd_data_i into hist_bin_o at N+2 and pulse axi_rd_ack_o at N+3, giving a fixed 3-cycle strobe-to-ack latency.
REQ-029 bin_idx SHALL increment by 1 on each ack, modulo 2^HIST_AW.
REQ-030 On the ack of bin 2^HIST_AW-1, SHALL pulse hist_clr_o in the same cycle, and bin_idx SHALL wrap to 0.
REQ-031 A read strobe while the read FSM is not in R_IDLE SHALL be ignored, with no ack and no index change.
REQ-032 Read and write paths SHALL be independent; simultaneous strobes SHALL both be serviced at their normal latencies.
REQ-033 All outputs SHALL be registered.

Reset
REQ-034 While rst=1, SHALL drive axi_wr_ack_o, axi_rd_ack_o, coef_we_o, hist_rd_en_o, hist_clr_o and busy_o to 0, and coef_addr_o, coef_data_o, hist_rd_addr_o and hist_bin_o to 0.
REQ-035 rst SHALL clear shadow registers to 0, dirty to 0, bin_idx to 0, registered vs_i to 0, and return both FSMs to idle.
REQ-036 rst asserted mid-COMMIT or mid-read SHALL abort the operation with no further coef_we_o or ack pulses, and SHALL not cause a commit after reset.

Verification
REQ-037 Write addr 2, data 0x0123 -> ack 1 cycle later; on the next vs rise, 9 coef_we_o pulses occur with addr 2 carrying 0x0123 and all other addresses carrying 0.
REQ-038 Write addr 12, data 0xFFFF -> ack 1 cycle later; at vs rise, no commit (dirty stays 0).
REQ-039 Write during COMMIT (addr 0, data 0x0005) -> ack given; the next frame commits again with addr 0 carrying 0x0005.
REQ-040 Perform 257 reads with RAM model data=addr -> acks 3 cycles after each strobe; values 0..255 then 0; hist_clr_o pulses once, with the 256th ack.
REQ-041 Read strobe at N and again at N+1 -> exactly one ack at N+3; bin_idx advances by 1.
REQ-042 Simultaneous read and write strobes, then rst asserted at the 4th cycle of COMMIT -> write ack at N+1 and read ack at N+3 precede reset; after reset, all outputs are 0 and no coef_we_o pulses occur on subsequent vs rises.
